// File: rtl/ppu_nt_fetch_tracker_if.sv
// PPU-side bus and qualified nametable-strobe outputs of ppu_nt_fetch_tracker.
interface ppu_nt_fetch_tracker_if;
    logic [13:0] ppu_addr;
    logic        ppu_oe_n;
    logic        ppu_we_n;
    logic        freeze;
    logic        nt_valid;
    logic        nt_wr;
    logic [11:0] nt_addr;
    logic        nt_is_attr;
    logic [6:0]  fetch_cnt;
    logic        line_end;
    logic        rendering;

    modport master (
        output ppu_addr, ppu_oe_n, ppu_we_n, freeze,
        input  nt_valid, nt_wr, nt_addr, nt_is_attr, fetch_cnt, line_end, rendering
    );

    modport slave (
        input  ppu_addr, ppu_oe_n, ppu_we_n, freeze,
        output nt_valid, nt_wr, nt_addr, nt_is_attr, fetch_cnt, line_end, rendering
    );
endinterface

// File: rtl/ppu_nt_fetch_tracker.sv
// Synchronises the raw PPU bus, qualifies each A13-high window and emits one
// strobe per nametable read or write, plus per-line fetch and rendering tracking.
module ppu_nt_fetch_tracker #(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 3,
    parameter int RENDER_TMO  = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ppu_nt_fetch_tracker_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;
    localparam logic [9:0] TMO_LIM    = 10'(RENDER_TMO);
    localparam logic [4:0] SETTLE_LIM = 5'(SETTLE_CYC);

    logic [15:0] sync_r [SYNC_STAGES];
    logic [13:0] sa_s;
    logic        soe_n_s;
    logic        swe_n_s;
    logic        oe_unused_s;
    logic        sa13_prev_r;

    logic [1:0]  state_r, state_s;
    logic [3:0]  settle_cnt_r, settle_cnt_s;
    logic [12:0] snap_r, snap_s;
    logic        wr_seen_r, wr_seen_s;
    logic        capture_s, valid_set_s, wr_set_s, line_end_set_s;

    logic        nt_valid_r, nt_wr_r, nt_is_attr_r, line_end_r, rendering_r;
    logic [11:0] nt_addr_r;
    logic [6:0]  fetch_cnt_r;
    logic [6:0]  gap_cnt_r;
    logic        armed_r;
    logic [9:0]  tmr_r;

    assign sa_s        = sync_r[SYNC_STAGES-1][13:0];
    assign swe_n_s     = sync_r[SYNC_STAGES-1][14];
    assign soe_n_s     = sync_r[SYNC_STAGES-1][15];
    // /RD is carried for timing parity; the read/write decision only needs /WR.
    assign oe_unused_s = soe_n_s;

    // Input synchroniser and A13 history; keeps running through freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 16'd0;
            sa13_prev_r <= 1'b0;
        end else begin
            sync_r[0] <= {bus.ppu_oe_n, bus.ppu_we_n, bus.ppu_addr};
            for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
            sa13_prev_r <= sa_s[13];
        end
    end

    // Fetch qualification FSM next-state and strobe decode.
    always_comb begin
        state_s      = state_r;
        settle_cnt_s = settle_cnt_r;
        snap_s       = snap_r;
        wr_seen_s    = wr_seen_r;
        capture_s    = 1'b0;
        valid_set_s  = 1'b0;
        wr_set_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sa_s[13] && !sa13_prev_r) begin
                    state_s      = ST_SETTLE;
                    settle_cnt_s = 4'd1;
                    snap_s       = sa_s[12:0];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!sa_s[13]) begin
                    state_s = ST_IDLE;
                end else if (sa_s[12:0] != snap_r) begin
                    snap_s       = sa_s[12:0];
                    settle_cnt_s = 4'd1;
                end else begin
                    settle_cnt_s = settle_cnt_r + 4'd1;
                    if (({1'b0, settle_cnt_r} + 5'd1) >= SETTLE_LIM) begin
                        state_s = ST_CAPTURE;
                    end else begin
                        state_s = ST_SETTLE;
                    end
                end
            end
            ST_CAPTURE: begin
                capture_s = 1'b1;
                wr_seen_s = !swe_n_s;
                state_s   = ST_HOLD;
            end
            ST_HOLD: begin
                wr_seen_s = wr_seen_r | !swe_n_s;
                // Level test so a fall that happened during freeze is still reported.
                if (!sa_s[13]) begin
                    state_s = ST_IDLE;
                    if (wr_seen_s) begin
                        wr_set_s = 1'b1;
                    end else begin
                        valid_set_s = 1'b1;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign line_end_set_s = armed_r && (gap_cnt_r == 7'd63) && !valid_set_s
                            && (fetch_cnt_r != 7'd0);

    // FSM state, captured outputs and line/rendering counters; all hold on freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            settle_cnt_r <= 4'd0;
            snap_r       <= 13'd0;
            wr_seen_r    <= 1'b0;
            nt_valid_r   <= 1'b0;
            nt_wr_r      <= 1'b0;
            line_end_r   <= 1'b0;
            nt_addr_r    <= 12'd0;
            nt_is_attr_r <= 1'b0;
            fetch_cnt_r  <= 7'd0;
            gap_cnt_r    <= 7'd0;
            armed_r      <= 1'b0;
            tmr_r        <= TMO_LIM;
            rendering_r  <= 1'b0;
        end else if (bus.freeze) begin
            nt_valid_r <= 1'b0;
            nt_wr_r    <= 1'b0;
            line_end_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            settle_cnt_r <= settle_cnt_s;
            snap_r       <= snap_s;
            wr_seen_r    <= wr_seen_s;
            nt_valid_r   <= valid_set_s;
            nt_wr_r      <= wr_set_s;
            line_end_r   <= line_end_set_s;
            if (capture_s) begin
                nt_addr_r    <= snap_r[11:0];
                nt_is_attr_r <= (snap_r[9:6] == 4'hF);
            end
            if (line_end_set_s) begin
                fetch_cnt_r <= 7'd0;
            end else if (valid_set_s && (fetch_cnt_r != 7'd127)) begin
                fetch_cnt_r <= fetch_cnt_r + 7'd1;
            end
            if (valid_set_s) begin
                gap_cnt_r <= 7'd0;
                armed_r   <= 1'b1;
            end else begin
                if (gap_cnt_r != 7'd64) gap_cnt_r <= gap_cnt_r + 7'd1;
                if (line_end_set_s) armed_r <= 1'b0;
            end
            if (valid_set_s) begin
                tmr_r       <= 10'd0;
                rendering_r <= 1'b1;
            end else if (tmr_r != TMO_LIM) begin
                tmr_r <= tmr_r + 10'd1;
                if ((tmr_r + 10'd1) == TMO_LIM) rendering_r <= 1'b0;
            end
        end
    end

    assign bus.nt_valid   = nt_valid_r;
    assign bus.nt_wr      = nt_wr_r;
    assign bus.nt_addr    = nt_addr_r;
    assign bus.nt_is_attr = nt_is_attr_r;
    assign bus.fetch_cnt  = fetch_cnt_r;
    assign bus.line_end   = line_end_r;
    assign bus.rendering  = rendering_r;
endmodule

// File: tb/tb_ppu_nt_fetch_tracker.sv
// Directed bench for ppu_nt_fetch_tracker with a strobe scoreboard.
module tb_ppu_nt_fetch_tracker;
    localparam int SYNC_STAGES = 2;
    localparam int SETTLE_CYC  = 3;
    localparam int RENDER_TMO  = 1023;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ppu_nt_fetch_tracker_if bus();

    ppu_nt_fetch_tracker #(
        .SYNC_STAGES(SYNC_STAGES),
        .SETTLE_CYC (SETTLE_CYC),
        .RENDER_TMO (RENDER_TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [11:0] addr;
        logic        attr;
    } exp_t;

    exp_t sb_q[$];
    int n_pass = 0;
    int n_total = 0;
    int pe_cnt = 0;
    int strobe_cnt = 0;
    int line_end_cnt = 0;
    int last_valid_pe = 0;
    int last_strobe_pe = 0;
    int line_end_pe = 0;
    int fall_pe = 0;
    logic [11:0] last_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One A13-high window of hi cycles; /WR low on cycles we_from..we_to for writes.
    task automatic access(input logic [12:0] a, input int hi, input int we_from, input int we_to,
                          input logic expect_strobe, input logic is_wr);
        exp_t e;
        if (expect_strobe) begin
            e.wr   = is_wr;
            e.addr = a[11:0];
            e.attr = (((a >> 6) & 13'h000F) == 13'h000F);
            sb_q.push_back(e);
        end
        bus.ppu_addr = {1'b1, a};
        bus.ppu_oe_n = is_wr;
        for (int i = 0; i < hi; i++) begin
            bus.ppu_we_n = !(is_wr && (i >= we_from) && (i <= we_to));
            step(1);
        end
        bus.ppu_addr[13] = 1'b0;
        bus.ppu_oe_n = 1'b1;
        bus.ppu_we_n = 1'b1;
        fall_pe = pe_cnt;
    endtask

    task automatic check_reset_values();
        check("rst_nt_valid", bus.nt_valid, 0);
        check("rst_nt_wr", bus.nt_wr, 0);
        check("rst_nt_addr", bus.nt_addr, 0);
        check("rst_nt_is_attr", bus.nt_is_attr, 0);
        check("rst_fetch_cnt", bus.fetch_cnt, 0);
        check("rst_line_end", bus.line_end, 0);
        check("rst_rendering", bus.rendering, 0);
    endtask

    always @(posedge clk) pe_cnt <= pe_cnt + 1;

    // Strobe monitor: every strobe must match the oldest scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.nt_valid || bus.nt_wr) begin
                strobe_cnt     <= strobe_cnt + 1;
                last_strobe_pe <= pe_cnt;
                if (bus.nt_valid) last_valid_pe <= pe_cnt;
                check("single_strobe_kind", {31'd0, bus.nt_valid & bus.nt_wr}, 0);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("strobe_is_wr", bus.nt_wr, e.wr);
                    check("strobe_addr", bus.nt_addr, e.addr);
                    check("strobe_attr", bus.nt_is_attr, e.attr);
                end else begin
                    check("unexpected_strobe", {bus.nt_wr, bus.nt_valid}, 0);
                end
            end
            if (bus.line_end) begin
                line_end_cnt <= line_end_cnt + 1;
                line_end_pe  <= pe_cnt;
            end
        end
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.ppu_addr = 14'h0000;
        bus.ppu_oe_n = 1'b1;
        bus.ppu_we_n = 1'b1;
        bus.freeze   = 1'b0;
        rst_n        = 1'b0;
        step(3);
        @(negedge clk);
        check_reset_values();
        step(1);
        rst_n = 1'b1;
        step(4);

        // Plain read at 0x2345
        access(13'h0345, 8, 0, -1, 1'b1, 1'b0);
        step(6);
        check("read_strobe_cnt", strobe_cnt, 1);
        check("read_latency", last_strobe_pe - fall_pe, SYNC_STAGES + 1);
        check("read_fetch_cnt", bus.fetch_cnt, 1);
        check("read_nt_addr", bus.nt_addr, 12'h345);
        check("read_attr", bus.nt_is_attr, 0);
        check("read_rendering", bus.rendering, 1);

        // Attribute fetch at 0x23C7
        access(13'h03C7, 8, 0, -1, 1'b1, 1'b0);
        step(6);
        check("attr_nt_is_attr", bus.nt_is_attr, 1);
        check("attr_nt_addr", bus.nt_addr, 12'h3C7);
        check("attr_fetch_cnt", bus.fetch_cnt, 2);

        // Two-cycle glitch is rejected
        access(13'h0100, 2, 0, -1, 1'b0, 1'b0);
        step(8);
        check("glitch_strobe_cnt", strobe_cnt, 2);
        check("glitch_fsm_idle", dut.state_r, 0);

        // Write path via /WR pulse mid-window
        access(13'h0001, 10, 4, 5, 1'b1, 1'b1);
        step(6);
        check("write_strobe_cnt", strobe_cnt, 3);
        check("write_fetch_cnt", bus.fetch_cnt, 2);
        check("write_nt_addr", bus.nt_addr, 12'h001);

        // Idle gap after the attribute read ends the line
        step(60);
        check("gap1_line_end_cnt", line_end_cnt, 1);
        check("gap1_line_end_delay", line_end_pe - last_valid_pe, 64);
        check("gap1_fetch_cnt", bus.fetch_cnt, 0);

        // 34-read line, then idle
        for (int i = 0; i < 34; i++) begin
            last_addr = 12'h800 + 12'(i * 37);
            access({1'b0, last_addr}, 8, 0, -1, 1'b1, 1'b0);
            step(4);
        end
        check("line_fetch_cnt", bus.fetch_cnt, 34);
        check("line_rendering", bus.rendering, 1);
        step(100);
        check("line_line_end_cnt", line_end_cnt, 2);
        check("line_line_end_delay", line_end_pe - last_valid_pe, 64);
        check("line_fetch_cleared", bus.fetch_cnt, 0);
        check("line_rendering_held", bus.rendering, 1);
        while (pe_cnt < last_valid_pe + RENDER_TMO - 1) @(negedge clk);
        check("render_before_tmo", bus.rendering, 1);
        @(negedge clk);
        check("render_at_tmo", bus.rendering, 0);

        // Full A13 pulse under freeze produces nothing
        step(1);
        bus.freeze = 1'b1;
        access(13'h0222, 8, 0, -1, 1'b0, 1'b0);
        step(6);
        bus.freeze = 1'b0;
        step(6);
        check("freeze_strobe_cnt", strobe_cnt, 37);
        check("freeze_nt_addr_held", bus.nt_addr, last_addr);

        // Async reset in the middle of HOLD
        bus.ppu_addr = 14'h2555;
        bus.ppu_oe_n = 1'b0;
        step(8);
        check("hold_reached", dut.state_r, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values();
        step(1);
        bus.ppu_addr[13] = 1'b0;
        bus.ppu_oe_n = 1'b1;
        step(3);
        rst_n = 1'b1;
        step(10);
        check("post_reset_strobe_cnt", strobe_cnt, 37);
        check("post_reset_nt_addr", bus.nt_addr, 0);
        check("post_reset_fsm_idle", dut.state_r, 0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
